// File: rtl/joy_serial_pkg.sv
// ---------------------------------------------------------------------------
// joy_serial_pkg
// Shared definitions for the serial joystick receiver:
//   - joy_state_e : frame sequencer states
//   - FILT_CNT_W  : width of the per-player stability counter (saturates at 15)
//   - idx_w/gap_w : clog2-based widths for the bit index and gap counter
// ---------------------------------------------------------------------------
package joy_serial_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_CLKHI  = 3'd3,
    ST_GAP    = 3'd4
  } joy_state_e;

  localparam int FILT_CNT_W = 4;

  // Bits needed to hold 0..value-1, never less than one bit.
  function automatic int clog2_min1(input int value);
    int width;
    int span;
    width = 32'sd1;
    span  = 32'sd2;
    while (span < value) begin
      width = width + 32'sd1;
      span  = span * 32'sd2;
    end
    return width;
  endfunction

  // Width of the bit index k (0..n-1).
  function automatic int idx_w(input int n);
    return clog2_min1(n);
  endfunction

  // Width of the gap counter, which must hold the value g itself.
  function automatic int gap_w(input int g);
    return clog2_min1(g + 32'sd1);
  endfunction

endpackage

// File: rtl/joy_serial_multi_if.sv
// ---------------------------------------------------------------------------
// joy_serial_multi_if
// Bundle of the receiver's chain and core-facing signals.
//   enable     : run frames (low forces idle)
//   joy_data   : serial data from the 74HC165 chain
//   joy_load   : parallel load, active-low
//   joy_clk    : chain shift clock (chain advances on rising edge)
//   joystick   : filtered buttons, player p at [p*BITS +: BITS]
//   frame_done : one-cycle pulse per captured frame
// master = receiver, slave = environment (pins / top level).
// ---------------------------------------------------------------------------
interface joy_serial_multi_if #(
  parameter int PLAYERS = 2,
  parameter int BITS    = 12
);
  logic                      enable;
  logic                      joy_data;
  logic                      joy_load;
  logic                      joy_clk;
  logic [PLAYERS*BITS-1:0]   joystick;
  logic                      frame_done;

  modport master (
    input  enable,
    input  joy_data,
    output joy_load,
    output joy_clk,
    output joystick,
    output frame_done
  );

  modport slave (
    output enable,
    output joy_data,
    input  joy_load,
    input  joy_clk,
    input  joystick,
    input  frame_done
  );
endinterface

// File: rtl/joy_stable_filter.sv
// ---------------------------------------------------------------------------
// joy_stable_filter
// One player's stability filter. On each i_valid the new word is compared
// with the candidate; matching words bump a saturating counter, a different
// word restarts the count at 1. The output follows the candidate once the
// count reaches STABLE_FRAMES.
//   clk, reset : clock, async active-high reset
//   i_valid    : new frame word available (one cycle)
//   i_word     : captured word for this player
//   o_word     : filtered output word
// ---------------------------------------------------------------------------
module joy_stable_filter
  import joy_serial_pkg::*;
#(
  parameter int BITS          = 12,
  parameter int STABLE_FRAMES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_valid,
  input  logic [BITS-1:0] i_word,
  output logic [BITS-1:0] o_word
);

  localparam logic [FILT_CNT_W-1:0] CNT_MAX = {FILT_CNT_W{1'b1}};
  localparam logic [FILT_CNT_W-1:0] CNT_THR = FILT_CNT_W'(STABLE_FRAMES);

  logic [BITS-1:0]       r_cand;
  logic [BITS-1:0]       r_word;
  logic [FILT_CNT_W-1:0] r_cnt;
  logic [FILT_CNT_W-1:0] w_cnt_nxt;

  // Post-update count: restart on a new word, otherwise saturate-increment.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_word != r_cand) begin
      w_cnt_nxt = FILT_CNT_W'(1);
    end else if (r_cnt != CNT_MAX) begin
      w_cnt_nxt = r_cnt + FILT_CNT_W'(1);
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  // Candidate, counter and output word registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cand <= '0;
      r_cnt  <= '0;
      r_word <= '0;
    end else if (i_valid) begin
      // After the update the candidate always equals the new word.
      r_cand <= i_word;
      r_cnt  <= w_cnt_nxt;
      if (w_cnt_nxt >= CNT_THR) begin
        r_word <= i_word;
      end
    end
  end

  assign o_word = r_word;

endmodule

// File: rtl/joy_serial_multi.sv
// ---------------------------------------------------------------------------
// joy_serial_multi
// Serial joystick receiver for a chain of 74HC165 shift registers.
// A tick divider paces a frame sequencer (IDLE, LOAD, SAMPLE/CLKHI per bit,
// GAP) that loads the chain, shifts in PLAYERS*BITS bits and hands each
// player's word to its own stability filter.
//   clk    : system clock
//   reset  : async active-high reset
//   io_bus : joy_serial_multi_if master (enable, joy_data, joy_load,
//            joy_clk, joystick, frame_done)
// ---------------------------------------------------------------------------
module joy_serial_multi
  import joy_serial_pkg::*;
#(
  parameter int PLAYERS       = 2,
  parameter int BITS          = 12,
  parameter int CLK_DIV       = 24,
  parameter int GAP_TICKS     = 64,
  parameter int STABLE_FRAMES = 2,
  parameter bit INVERT        = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  joy_serial_multi_if.master   io_bus
);

  localparam int N     = PLAYERS * BITS;
  localparam int IDX_W = idx_w(N);
  localparam int GAP_W = gap_w(GAP_TICKS);
  localparam int DIV_W = idx_w(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_TICKS);

  logic [DIV_W-1:0] r_div;
  joy_state_e       r_state;
  logic             r_load;
  logic             r_clk;
  logic             r_done;
  logic [IDX_W-1:0] r_k;
  logic [GAP_W-1:0] r_gap;
  logic [N-1:0]     r_shift;

  logic             w_tick;
  joy_state_e       w_state_nxt;
  logic             w_load_nxt;
  logic             w_clk_nxt;
  logic             w_done_nxt;
  logic             w_sample;
  logic [IDX_W-1:0] w_k_nxt;
  logic [GAP_W-1:0] w_gap_nxt;
  logic [N-1:0]     w_joystick;

  assign w_tick = (r_div == DIV_LAST);

  // Free-running tick divider.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // Next-state and next-output logic; dropping enable overrides the tick.
  always_comb begin
    w_state_nxt = r_state;
    w_load_nxt  = r_load;
    w_clk_nxt   = r_clk;
    w_k_nxt     = r_k;
    w_gap_nxt   = r_gap;
    w_done_nxt  = 1'b0;
    w_sample    = 1'b0;
    if (!io_bus.enable) begin
      w_state_nxt = ST_IDLE;
      w_load_nxt  = 1'b1;
      w_clk_nxt   = 1'b1;
    end else if (w_tick) begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_LOAD;
          w_load_nxt  = 1'b0;
        end
        ST_LOAD: begin
          w_state_nxt = ST_SAMPLE;
          w_load_nxt  = 1'b1;
          w_k_nxt     = '0;
        end
        ST_SAMPLE: begin
          // Data is taken at the end of the high phase, right before the fall.
          w_state_nxt = ST_CLKHI;
          w_sample    = 1'b1;
          w_clk_nxt   = 1'b0;
        end
        ST_CLKHI: begin
          w_clk_nxt = 1'b1;
          if (r_k == IDX_LAST) begin
            w_state_nxt = ST_GAP;
            w_done_nxt  = 1'b1;
            w_gap_nxt   = GAP_LOAD;
          end else begin
            w_state_nxt = ST_SAMPLE;
            w_k_nxt     = r_k + IDX_W'(1);
          end
        end
        ST_GAP: begin
          w_gap_nxt = r_gap - GAP_W'(1);
          if (r_gap <= GAP_W'(1)) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_GAP;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_load_nxt  = 1'b1;
          w_clk_nxt   = 1'b1;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Sequencer state, registered chain outputs and the capture shift register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_load  <= 1'b1;
      r_clk   <= 1'b1;
      r_done  <= 1'b0;
      r_k     <= '0;
      r_gap   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_load  <= w_load_nxt;
      r_clk   <= w_clk_nxt;
      r_done  <= w_done_nxt;
      r_k     <= w_k_nxt;
      r_gap   <= w_gap_nxt;
      if (w_sample) begin
        r_shift[r_k] <= io_bus.joy_data ^ INVERT;
      end
    end
  end

  // Filters update on the same edge that raises frame_done, so with
  // STABLE_FRAMES=1 the new word is visible while frame_done is high.
  for (genvar p = 0; p < PLAYERS; p++) begin : g_player
    joy_stable_filter #(
      .BITS          (BITS),
      .STABLE_FRAMES (STABLE_FRAMES)
    ) u_filter (
      .clk     (clk),
      .reset   (reset),
      .i_valid (w_done_nxt),
      .i_word  (r_shift[p*BITS +: BITS]),
      .o_word  (w_joystick[p*BITS +: BITS])
    );
  end

  assign io_bus.joy_load   = r_load;
  assign io_bus.joy_clk    = r_clk;
  assign io_bus.frame_done = r_done;
  assign io_bus.joystick   = w_joystick;

endmodule

// File: tb/tb_joy_serial_multi.sv
// ---------------------------------------------------------------------------
// tb_joy_serial_multi
// Three receivers: A (2x4, STABLE_FRAMES=1), B (2x4, STABLE_FRAMES=2) and
// C (4x16, CLK_DIV=24, GAP_TICKS=64), each fed by a 74HC165 chain model.
// A and B run in lockstep through a table of frames; A then sees an enable
// drop mid-frame and an async reset mid-frame; C checks full-size timing.
// ---------------------------------------------------------------------------
module tb_joy_serial_multi;

  typedef struct {
    logic [7:0] raw_a;
    logic [7:0] exp_a;
    logic [7:0] raw_b;
    logic [7:0] exp_b;
  } vec_t;

  logic        clk;
  logic        rst_a;
  logic        rst_bc;
  logic        en_a, en_b, en_c;
  logic [7:0]  raw_a, raw_b, sh_a, sh_b;
  logic [63:0] raw_c, sh_c;
  int          n_tests;
  int          n_fail;
  vec_t        tbl [7];

  joy_serial_multi_if #(.PLAYERS(2), .BITS(4))  if_a ();
  joy_serial_multi_if #(.PLAYERS(2), .BITS(4))  if_b ();
  joy_serial_multi_if #(.PLAYERS(4), .BITS(16)) if_c ();

  joy_serial_multi #(.PLAYERS(2), .BITS(4), .CLK_DIV(2), .GAP_TICKS(2),
                     .STABLE_FRAMES(1), .INVERT(1'b1))
    dut_a (.clk(clk), .reset(rst_a), .io_bus(if_a.master));
  joy_serial_multi #(.PLAYERS(2), .BITS(4), .CLK_DIV(2), .GAP_TICKS(2),
                     .STABLE_FRAMES(2), .INVERT(1'b1))
    dut_b (.clk(clk), .reset(rst_bc), .io_bus(if_b.master));
  joy_serial_multi #(.PLAYERS(4), .BITS(16), .CLK_DIV(24), .GAP_TICKS(64),
                     .STABLE_FRAMES(1), .INVERT(1'b1))
    dut_c (.clk(clk), .reset(rst_bc), .io_bus(if_c.master));

  assign if_a.enable   = en_a;
  assign if_b.enable   = en_b;
  assign if_c.enable   = en_c;
  assign if_a.joy_data = sh_a[0];
  assign if_b.joy_data = sh_b[0];
  assign if_c.joy_data = sh_c[0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 74HC165 chain models: parallel load while load is low, shift on joy_clk rise.
  always @(posedge if_a.joy_clk or negedge if_a.joy_load)
    if (!if_a.joy_load) sh_a <= raw_a; else sh_a <= {1'b1, sh_a[7:1]};
  always @(posedge if_b.joy_clk or negedge if_b.joy_load)
    if (!if_b.joy_load) sh_b <= raw_b; else sh_b <= {1'b1, sh_b[7:1]};
  always @(posedge if_c.joy_clk or negedge if_c.joy_load)
    if (!if_c.joy_load) sh_c <= raw_c; else sh_c <= {1'b1, sh_c[63:1]};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Wait for frame_done on A (sel=0) or C (sel=2), counting cycles and chain activity.
  task automatic wait_frame(input int sel, input int budget, output int cyc,
                            output int load_lo, output int clk_lo, output int rises,
                            output logic got);
    logic l, c, d, c_prev;
    cyc = 0; load_lo = 0; clk_lo = 0; rises = 0; got = 1'b0;
    c_prev = (sel == 0) ? if_a.joy_clk : if_c.joy_clk;
    while (!got && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (sel == 0) begin l = if_a.joy_load; c = if_a.joy_clk; d = if_a.frame_done; end
      else          begin l = if_c.joy_load; c = if_c.joy_clk; d = if_c.frame_done; end
      if (!l) load_lo++;
      if (!c) clk_lo++;
      if (c && !c_prev) rises++;
      c_prev = c;
      if (d) got = 1'b1;
    end
  endtask

  initial begin
    int cyc, llo, clo, rs, r;
    logic got, cp, hit;
    logic bad_load, bad_clk, bad_done, bad_joy;

    n_tests = 0;
    n_fail  = 0;
    tbl[0] = '{8'hA5, 8'h5A, 8'hC9, 8'h00};
    tbl[1] = '{8'h00, 8'hFF, 8'h39, 8'h06};
    tbl[2] = '{8'hFF, 8'h00, 8'hC9, 8'h06};
    tbl[3] = '{8'h3C, 8'hC3, 8'h39, 8'h06};
    tbl[4] = '{8'h0F, 8'hF0, 8'hC9, 8'h06};
    tbl[5] = '{8'h12, 8'hED, 8'hC9, 8'h36};
    tbl[6] = '{8'h12, 8'hED, 8'h69, 8'h36};

    rst_a = 1'b1; rst_bc = 1'b1;
    en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;
    raw_a = tbl[0].raw_a; raw_b = tbl[0].raw_b;
    raw_c = 64'h0123_4567_89AB_CDEF;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_load",  if_a.joy_load, 1'b1);
    chk("rst_clk",   if_a.joy_clk, 1'b1);
    chk("rst_joy",   if_a.joystick, 8'h00);
    chk("rst_done",  if_a.frame_done, 1'b0);
    chk("rst_joy_c", if_c.joystick, 64'h0);
    rst_a = 1'b0; rst_bc = 1'b0;

    // Table of frames on A (follows every frame) and B (two-frame filter)
    for (int i = 0; i < 7; i++) begin
      raw_a = tbl[i].raw_a;
      raw_b = tbl[i].raw_b;
      wait_frame(0, 200, cyc, llo, clo, rs, got);
      chk($sformatf("frame%0d_seen", i), got, 1'b1);
      chk($sformatf("frame%0d_joy_a", i), if_a.joystick, tbl[i].exp_a);
      chk($sformatf("frame%0d_done_b", i), if_b.frame_done, 1'b1);
      chk($sformatf("frame%0d_joy_b", i), if_b.joystick, tbl[i].exp_b);
      chk($sformatf("frame%0d_load_low", i), llo, 2);
      chk($sformatf("frame%0d_clk_low", i), clo, 16);
      chk($sformatf("frame%0d_clk_pulses", i), rs, 8);
      if (i > 0) chk($sformatf("frame%0d_period", i), cyc, 40);
    end

    // Enable dropped during SAMPLE of bit 5
    raw_a = 8'h5C;
    r = 0; cp = if_a.joy_clk;
    for (int t = 0; t < 200 && r < 5; t++) begin
      @(negedge clk);
      if (if_a.joy_clk && !cp) r++;
      cp = if_a.joy_clk;
    end
    chk("drop_reach_bit5", r, 5);
    en_a = 1'b0;
    bad_load = 1'b0; bad_clk = 1'b0; bad_done = 1'b0; bad_joy = 1'b0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (if_a.joy_load !== 1'b1) bad_load = 1'b1;
      if (if_a.joy_clk !== 1'b1) bad_clk = 1'b1;
      if (if_a.frame_done !== 1'b0) bad_done = 1'b1;
      if (if_a.joystick !== 8'hED) bad_joy = 1'b1;
    end
    chk("drop_load_high", bad_load, 1'b0);
    chk("drop_clk_high", bad_clk, 1'b0);
    chk("drop_no_done", bad_done, 1'b0);
    chk("drop_joy_held", bad_joy, 1'b0);
    en_a = 1'b1;
    wait_frame(0, 200, cyc, llo, clo, rs, got);
    chk("reen_seen", got, 1'b1);
    chk("reen_joy", if_a.joystick, 8'hA3);
    chk("reen_clk_pulses", rs, 8);
    chk("reen_load_low", llo, 2);

    // Async reset pulse mid-frame, while joy_clk is low
    raw_a = 8'h77;
    r = 0; cp = if_a.joy_clk; hit = 1'b0;
    for (int t = 0; t < 200 && !hit; t++) begin
      @(negedge clk);
      if (if_a.joy_clk && !cp) r++;
      cp = if_a.joy_clk;
      if (r >= 3 && !if_a.joy_clk) hit = 1'b1;
    end
    chk("arst_reach_mid", hit, 1'b1);
    #2 rst_a = 1'b1;
    #1;
    chk("arst_load", if_a.joy_load, 1'b1);
    chk("arst_clk", if_a.joy_clk, 1'b1);
    chk("arst_joy", if_a.joystick, 8'h00);
    chk("arst_done", if_a.frame_done, 1'b0);
    raw_a = 8'h96;
    repeat (2) @(posedge clk);
    #3 rst_a = 1'b0;
    wait_frame(0, 200, cyc, llo, clo, rs, got);
    chk("arst_after_seen", got, 1'b1);
    chk("arst_after_joy", if_a.joystick, 8'h69);
    chk("arst_after_pulses", rs, 8);
    chk("arst_after_load_low", llo, 2);

    // Full-size chain: 4 players x 16 bits, CLK_DIV=24, GAP_TICKS=64
    wait_frame(2, 6000, cyc, llo, clo, rs, got);
    chk("big_first_seen", got, 1'b1);
    chk("big_first_joy", if_c.joystick, 64'hFEDC_BA98_7654_3210);
    wait_frame(2, 6000, cyc, llo, clo, rs, got);
    chk("big_seen", got, 1'b1);
    chk("big_period", cyc, 4656);
    chk("big_clk_pulses", rs, 64);
    chk("big_clk_low", clo, 1536);
    chk("big_load_low", llo, 24);
    chk("big_joy", if_c.joystick, 64'hFEDC_BA98_7654_3210);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/joy_serial_multi.md
# joy_serial_multi

Parametrised serial joystick receiver for the UserIO port, the successor to the fixed two-player DB15 reader. It drives a 74HC165-style chain (`joy_load`, `joy_clk`) and shifts in `PLAYERS × BITS` button bits per frame. Each player's word passes through a per-player stability filter before it reaches the core. The block sits between the USER_IN/USER_OUT pins and the joystick mux in the top level.

## Interface
Parameters:
- `PLAYERS`, 2: number of chained controllers, 1..4.
- `BITS`, 12: bits per controller, 1..16.
- `CLK_DIV`, 24: `clk` cycles per tick, ≥2.
- `GAP_TICKS`, 64: idle ticks between frames, ≥1.
- `STABLE_FRAMES`, 2: identical consecutive frames required before an output update, 1..15.
- `INVERT`, 1: 1 means chain data is active-low, so it is inverted on capture.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: system clock, 40–50 MHz.
- `reset` in 1: async active-high reset.
- `enable` in 1: run frames; low forces idle.
- `joy_data` in 1: serial data from the chain.
- `joy_load` out 1: parallel load, active-low.
- `joy_clk` out 1: shift clock; the chain advances on its rising edge.
- `joystick` out `PLAYERS*BITS`: filtered buttons, active-high; player p occupies `[p*BITS +: BITS]`.
- `frame_done` out 1: one-cycle pulse when a frame is captured.

## Operation
- **Tick divider:** counter 0..`CLK_DIV`-1. `tick` is high when the count equals `CLK_DIV`-1. The counter is free-running and cleared by reset.
- **FSM:** all transitions below occur on `tick`, except forced IDLE.
  - IDLE: `joy_load`=1, `joy_clk`=1. If `enable`, go to LOAD and drive `joy_load`=0.
  - LOAD: drive `joy_load`=1, clear bit index k, go to SAMPLE.
  - SAMPLE: capture `joy_data ^ INVERT` into shift bit k, drive `joy_clk`=0, go to CLKHI.
  - CLKHI: drive `joy_clk`=1.
    - If k = N-1 (N = `PLAYERS*BITS`), capture is complete: pulse `frame_done`, update the filters, load the gap counter, go to GAP.
    - Otherwise increment k and go to SAMPLE.
  - GAP: decrement the gap counter once per tick; when it reaches 0, go to IDLE.
- **Bit order:** the first bit captured is player 0 bit 0. Bit k maps to `joystick[k]`.
- **Stability filter, per player p, on `frame_done`:**
  - If the new word equals `cand[p]`, saturate-increment `cnt[p]`. Otherwise set `cand[p]` to the new word and `cnt[p]` to 1.
  - When the post-update `cnt[p]` ≥ `STABLE_FRAMES`, set the output word to `cand[p]` in the same cycle.
  - Players are filtered independently.
- **`enable` deasserted:**
  - Next cycle: state = IDLE, `joy_load`=1, `joy_clk`=1. This takes priority over the tick.
  - The partial frame is discarded: no `frame_done`, filters untouched.
  - `joystick` holds its value.
- **Reset values:** `joy_load`=1, `joy_clk`=1, `joystick`=0, `frame_done`=0, all `cand`/`cnt`=0, state IDLE.
- **Reset mid-frame:** outputs return to the reset values asynchronously. There is no glitch requirement beyond a monotonic return to 1 on `joy_clk` and `joy_load`.

## Timing
- `joy_load` low: exactly `CLK_DIV` cycles.
- `joy_clk` low phase: `CLK_DIV` cycles. `joy_data` is sampled at the end of the high phase, immediately before the falling edge.
- Frame period with `enable` held: (2 + 2N + `GAP_TICKS`) ticks.
- Output latency:
  - With `STABLE_FRAMES`=1, `joystick` updates in the same cycle `frame_done` is high (registered on the final CLKHI tick).
  - With `STABLE_FRAMES`=S, a changed input reaches `joystick` on the S-th consecutive identical frame.

## Structure
- `joy_serial_pkg` holds:
  - the state enum (IDLE, LOAD, SAMPLE, CLKHI, GAP);
  - the width functions `clog2`-based `IDX_W` and `GAP_W`.
- Sub-module `joy_stable_filter`: per-player candidate, counter and output register, parametrised by `BITS` and `STABLE_FRAMES`. It is instantiated `PLAYERS` times via generate.

## Test plan
Common setup for all scenarios: `PLAYERS`=2, `BITS`=4, `CLK_DIV`=2, `GAP_TICKS`=2, `INVERT`=1, chain model = 8-bit 74HC165.

1. Reset released, `enable`=1 → first `joy_load` low 2 cycles long; 8 `joy_clk` pulses, each 2 cycles low and 2 high; `frame_done` every 40 cycles.
2. `STABLE_FRAMES`=1, chain loads raw `8'hA5` → `joystick`=`8'h5A` in the `frame_done` cycle of frame 1.
3. `STABLE_FRAMES`=2:
   - P0 constant, P1 alternates `4'h3`/`4'hC` → P0 updates after frame 2; P1 never updates from 0.
   - P1 then held at `4'h3` for 2 frames → P1=`4'h3`.
4. `enable` dropped during SAMPLE of bit 5 → next cycle `joy_clk`=1 and `joy_load`=1; no `frame_done`; `joystick` unchanged.
   - Re-enable → full 8-bit frame, correct data.
5. Async `reset` pulse mid-frame (not clock-aligned) → outputs immediately at their reset values; the first frame after release is complete and correct.
6. `PLAYERS`=4, `BITS`=16, `CLK_DIV`=24 at 48 MHz → 64 clock pulses at 1 MHz; frame period = (2+128+64)×24 cycles.
